barrel_shifter_pipe: RTL and testbench

- Parametrised, pipelined successor to the 16-bit combinational barrel shifter.
- Generic WIDTH (power of two), one registered log2 shift stage per shift-amount bit.
- Adds arithmetic-right mode and valid/ready handshakes on input and output.
- Sits between a producer (switch/UART front end) and a consumer (display/FIFO) in the lab datapath; sustains one result per clock with backpressure.

---
 rtl/barrel_shifter_pipe_pkg.sv | 11 +
 rtl/barrel_shifter_pipe_stage.sv | 78 +++++++
 rtl/barrel_shifter_pipe.sv | 74 +++++++
 tb/tb_barrel_shifter_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shifter_pipe_pkg.sv
// Shared encodings for the pipelined barrel shifter: shift modes and directions.
package barrel_pkg;

  localparam logic [1:0] MODE_LOG  = 2'b00;
  localparam logic [1:0] MODE_ROT  = 2'b01;
  localparam logic [1:0] MODE_ARI  = 2'b10;

  localparam logic       DIR_LEFT  = 1'b0;
  localparam logic       DIR_RIGHT = 1'b1;

endpackage

// File: rtl/barrel_shifter_pipe_stage.sv
// One pipeline stage: conditional shift by DIST, registered together with the
// transaction's valid bit, original sign bit, direction, mode and shift amount.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  input  logic             sign,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [SHW-1:0]   shamt,
  output logic             valid_r,
  output logic [WIDTH-1:0] data_r,
  output logic             sign_r,
  output logic             dir_r,
  output logic [1:0]       mode_r,
  output logic [SHW-1:0]   shamt_r
);

  localparam int BIT = $clog2(DIST);

  logic [WIDTH-1:0] shifted_s;

  // Shift by DIST when this stage's shamt bit is set, otherwise pass through.
  always_comb begin
    shifted_s = data;
    if (shamt[BIT]) begin
      case (dir)
        DIR_LEFT: begin
          if (mode == MODE_ROT) begin
            shifted_s = {data[WIDTH-1-DIST:0], data[WIDTH-1:WIDTH-DIST]};
          end else begin
            shifted_s = data << DIST;
          end
        end
        DIR_RIGHT: begin
          // Arithmetic fill uses the sign carried from the operand, not data's MSB.
          case (mode)
            MODE_ROT: shifted_s = {data[DIST-1:0], data[WIDTH-1:DIST]};
            MODE_ARI: shifted_s = {{DIST{sign}}, data[WIDTH-1:DIST]};
            MODE_LOG: shifted_s = data >> DIST;
            default:  shifted_s = data >> DIST;
          endcase
        end
        default: shifted_s = data;
      endcase
    end else begin
      shifted_s = data;
    end
  end

  // Stage registers advance when enabled and hold during a global stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      sign_r  <= 1'b0;
      dir_r   <= 1'b0;
      mode_r  <= 2'b00;
      shamt_r <= '0;
    end else if (en) begin
      valid_r <= valid;
      data_r  <= shifted_s;
      sign_r  <= sign;
      dir_r   <= dir;
      mode_r  <= mode;
      shamt_r <= shamt;
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one registered power-of-two shift stage per shamt
// bit, valid/ready on both sides with a single global stall.
module barrel_shifter_pipe
  import barrel_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  // Index 0 is the input side; index k+1 is the register bank of stage k.
  logic [SHW:0]     vld_s;
  logic [SHW:0]     sign_s;
  logic [SHW:0]     dir_s;
  logic [WIDTH-1:0] data_s  [SHW+1];
  logic [1:0]       mode_s  [SHW+1];
  logic [SHW-1:0]   shamt_s [SHW+1];
  logic             stall_s;
  logic             unused_tail_s;

  assign vld_s[0]   = in_valid;
  assign data_s[0]  = din;
  assign sign_s[0]  = din[WIDTH-1];
  assign dir_s[0]   = dir;
  assign mode_s[0]  = mode;
  assign shamt_s[0] = shamt;

  assign stall_s  = vld_s[SHW] & ~out_ready;
  assign in_ready = ~stall_s;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    barrel_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k),
      .SHW   (SHW)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (~stall_s),
      .valid   (vld_s[k]),
      .data    (data_s[k]),
      .sign    (sign_s[k]),
      .dir     (dir_s[k]),
      .mode    (mode_s[k]),
      .shamt   (shamt_s[k]),
      .valid_r (vld_s[k+1]),
      .data_r  (data_s[k+1]),
      .sign_r  (sign_s[k+1]),
      .dir_r   (dir_s[k+1]),
      .mode_r  (mode_s[k+1]),
      .shamt_r (shamt_s[k+1])
    );
  end

  assign out_valid = vld_s[SHW];
  assign dout      = data_s[SHW];
  assign busy      = |vld_s[SHW:1];

  // Control fields of the last stage have no further consumer.
  assign unused_tail_s = ^{sign_s[SHW], dir_s[SHW], mode_s[SHW], shamt_s[SHW]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench: directed vectors, stream/stall/reset sequences and a
// randomized scoreboard run on WIDTH = 16, 32 and 8 instances sharing stimulus.
module tb_barrel_shifter_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        dir;
  logic [1:0]  mode;
  logic [31:0] din;
  logic [4:0]  shamt;

  logic        in_ready16, out_valid16, busy16;
  logic [15:0] dout16;
  logic        in_ready32, out_valid32, busy32;
  logic [31:0] dout32;
  logic        in_ready8, out_valid8, busy8;
  logic [7:0]  dout8;

  int checks = 0;
  int errors = 0;
  logic sb_on = 1'b0;
  logic [31:0] q16[$];
  logic [31:0] q32[$];
  logic [31:0] q8[$];

  always #5 clk = ~clk;

  barrel_shifter_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .din(din[15:0]), .shamt(shamt[3:0]), .dir(dir), .mode(mode),
    .out_valid(out_valid16), .out_ready(out_ready), .dout(dout16), .busy(busy16));

  barrel_shifter_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .din(din), .shamt(shamt), .dir(dir), .mode(mode),
    .out_valid(out_valid32), .out_ready(out_ready), .dout(dout32), .busy(busy32));

  barrel_shifter_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .din(din[7:0]), .shamt(shamt[2:0]), .dir(dir), .mode(mode),
    .out_valid(out_valid8), .out_ready(out_ready), .dout(dout8), .busy(busy8));

  // Reference: whole-word arithmetic on a 64-bit container, masked to width w.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int w, input int sh,
                                            input logic dr, input logic [1:0] md);
    longint unsigned mask, u, r;
    longint s;
    mask = (64'd1 << w) - 64'd1;
    u = {32'd0, d} & mask;
    if (dr == 1'b0) begin
      r = (md == 2'b01) ? ((u << sh) | (u >> (w - sh))) : (u << sh);
    end else if (md == 2'b01) begin
      r = (u >> sh) | (u << (w - sh));
    end else if (md == 2'b10) begin
      s = $signed(u << (64 - w));
      s = s >>> (64 - w + sh);
      r = $unsigned(s);
    end else begin
      r = u >> sh;
    end
    return 32'(r & mask);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] s,
                       input logic dr, input logic [1:0] md);
    in_valid = v;
    din      = d;
    shamt    = s;
    dir      = dr;
    mode     = md;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((busy16 | busy32 | busy8) && n < 30) begin
      step();
      n++;
    end
    check(name, 32'(busy16 | busy32 | busy8), 32'd0);
  endtask

  // Scoreboard and output-hold monitor, sampled mid-cycle for the next edge.
  logic        held16 = 1'b0;
  logic [15:0] hold16;
  always @(negedge clk) begin
    if (sb_on) begin
      if (held16) check("hold16", {15'd0, out_valid16, dout16}, {15'd0, 1'b1, hold16});
      held16 = out_valid16 & ~out_ready;
      hold16 = dout16;
      if (in_valid && in_ready16) q16.push_back(ref_shift(din, 16, int'(shamt[3:0]), dir, mode));
      if (in_valid && in_ready32) q32.push_back(ref_shift(din, 32, int'(shamt), dir, mode));
      if (in_valid && in_ready8)  q8.push_back(ref_shift(din, 8, int'(shamt[2:0]), dir, mode));
      if (out_valid16 && out_ready) begin
        if (q16.size() == 0) check("sb16_unexpected", {16'd0, dout16}, 32'hFFFF_FFFF);
        else check("sb16", {16'd0, dout16}, q16.pop_front());
      end
      if (out_valid32 && out_ready) begin
        if (q32.size() == 0) check("sb32_unexpected", dout32, ~dout32);
        else check("sb32", dout32, q32.pop_front());
      end
      if (out_valid8 && out_ready) begin
        if (q8.size() == 0) check("sb8_unexpected", {24'd0, dout8}, 32'hFFFF_FFFF);
        else check("sb8", {24'd0, dout8}, q8.pop_front());
      end
    end else begin
      held16 = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] din;
    logic [3:0]  shamt;
    logic        dir;
    logic [1:0]  mode;
    logic [15:0] want;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int lat, n, gap, k;
    int l16, l32, l8;
    logic [31:0] d16, d32, d8, e16, e32, e8;
    logic [31:0] st_exp [3];

    vecs[0]  = '{16'hA738, 4'd4,  1'b0, 2'b00, 16'h7380};
    vecs[1]  = '{16'hA738, 4'd4,  1'b1, 2'b01, 16'h8A73};
    vecs[2]  = '{16'hA738, 4'd4,  1'b1, 2'b10, 16'hFA73};
    vecs[3]  = '{16'hA738, 4'd8,  1'b1, 2'b00, 16'h00A7};
    vecs[4]  = '{16'hA738, 4'd1,  1'b0, 2'b01, 16'h4E71};
    vecs[5]  = '{16'hA738, 4'd0,  1'b1, 2'b10, 16'hA738};
    vecs[6]  = '{16'hA738, 4'd3,  1'b0, 2'b10, 16'h39C0};
    vecs[7]  = '{16'hA738, 4'd4,  1'b0, 2'b11, 16'h7380};
    vecs[8]  = '{16'hA738, 4'd4,  1'b1, 2'b11, 16'h0A73};
    vecs[9]  = '{16'h5A38, 4'd4,  1'b1, 2'b10, 16'h05A3};
    vecs[10] = '{16'h8001, 4'd15, 1'b1, 2'b10, 16'hFFFF};
    vecs[11] = '{16'h8001, 4'd15, 1'b0, 2'b01, 16'hC000};

    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 5'd0, 1'b0, 2'b00);
    #2;
    check("rst_out_valid", 32'(out_valid16), 32'd0);
    check("rst_dout",      {16'd0, dout16}, 32'd0);
    check("rst_busy",      32'(busy16), 32'd0);
    check("rst_in_ready",  32'(in_ready16), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors, one at a time, with accept-to-result latency.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, {16'd0, vecs[i].din}, {1'b0, vecs[i].shamt}, vecs[i].dir, vecs[i].mode);
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid16 && lat < 20) begin
        step();
        lat++;
      end
      check($sformatf("lat16_v%0d", i), 32'(lat), 32'd4);
      check($sformatf("vec16_v%0d", i), {16'd0, dout16}, {16'd0, vecs[i].want});
      step();
    end
    wait_idle("idle_after_vectors");

    // Latency and result for all three widths on random operands.
    for (int r = 0; r < 4; r++) begin
      drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      e16 = ref_shift(din, 16, int'(shamt[3:0]), dir, mode);
      e32 = ref_shift(din, 32, int'(shamt), dir, mode);
      e8  = ref_shift(din, 8, int'(shamt[2:0]), dir, mode);
      step();
      in_valid = 1'b0;
      l16 = 0; l32 = 0; l8 = 0;
      d16 = 32'd0; d32 = 32'd0; d8 = 32'd0;
      for (lat = 1; lat < 20; lat++) begin
        if (out_valid16 && l16 == 0) begin l16 = lat; d16 = {16'd0, dout16}; end
        if (out_valid32 && l32 == 0) begin l32 = lat; d32 = dout32; end
        if (out_valid8  && l8  == 0) begin l8  = lat; d8  = {24'd0, dout8}; end
        if (l16 != 0 && l32 != 0 && l8 != 0) break;
        step();
      end
      check("lat16", 32'(l16), 32'd4);
      check("lat32", 32'(l32), 32'd5);
      check("lat8",  32'(l8),  32'd3);
      check("res16", d16, e16);
      check("res32", d32, e32);
      check("res8",  d8,  e8);
      wait_idle("idle_after_latency");
    end

    // Back-to-back stream of shamt 0..15: 16 consecutive results, in order.
    k = 0;
    gap = 0;
    for (int c = 0; c < 24; c++) begin
      if (out_valid16) begin
        check($sformatf("stream_%0d", k), {16'd0, dout16}, ref_shift(32'hA738, 16, k, 1'b0, 2'b00));
        k++;
      end else if (k > 0 && k < 16) begin
        gap++;
      end
      if (c < 16) drive(1'b1, 32'hA738, 5'(c), 1'b0, 2'b00);
      else in_valid = 1'b0;
      step();
    end
    check("stream_count", 32'(k), 32'd16);
    check("stream_gaps",  32'(gap), 32'd0);
    wait_idle("idle_after_stream");

    // Backpressure with three transactions in flight.
    for (int c = 0; c < 3; c++) begin
      st_exp[c] = ref_shift(32'hA738, 16, c + 1, 1'b0, 2'b01);
      drive(1'b1, 32'hA738, 5'(c + 1), 1'b0, 2'b01);
      step();
    end
    in_valid = 1'b0;
    step();
    check("stall_pre_valid", 32'(out_valid16), 32'd1);
    out_ready = 1'b0;
    drive(1'b1, 32'h1111, 5'd1, 1'b0, 2'b00);
    #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall_in_ready_%0d", c),  32'(in_ready16), 32'd0);
      check($sformatf("stall_out_valid_%0d", c), 32'(out_valid16), 32'd1);
      check($sformatf("stall_dout_%0d", c),      {16'd0, dout16}, st_exp[0]);
      check($sformatf("stall_busy_%0d", c),      32'(busy16), 32'd1);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid16) begin
        if (n < 3) check($sformatf("release_%0d", n), {16'd0, dout16}, st_exp[n]);
        n++;
      end
      step();
    end
    check("release_count", 32'(n), 32'd3);
    wait_idle("idle_after_stall");

    // Asynchronous reset mid-burst, then a fresh transaction.
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 32'hA738, 5'(c), 1'b0, 2'b00);
      step();
    end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid16), 32'd0);
    check("midrst_busy",      32'(busy16), 32'd0);
    check("midrst_dout",      {16'd0, dout16}, 32'd0);
    check("midrst_in_ready",  32'(in_ready16), 32'd1);
    rst_n = 1'b1;
    drive(1'b1, 32'h1234, 5'd4, 1'b0, 2'b00);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 20) begin
      step();
      lat++;
    end
    check("postrst_lat",  32'(lat), 32'd4);
    check("postrst_dout", {16'd0, dout16}, 32'h0000_2340);
    wait_idle("idle_after_reset");

    // Randomized traffic with random backpressure on all three widths.
    sb_on = 1'b1;
    for (int c = 0; c < 800; c++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      out_ready = 1'($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) step();
    sb_on = 1'b0;
    check("sb16_left", 32'(q16.size()), 32'd0);
    check("sb32_left", 32'(q32.size()), 32'd0);
    check("sb8_left",  32'(q8.size()),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
